dma_burst_ctrl: RTL and testbench
=================================

// Module: dma_burst_ctrl
// PURPOSE
//  Transfer sequencer that sits directly upstream of the AXI DMA native port. Splits a
//  software-programmed transfer (base address, word count, direction) into AXI bursts and
//  drives valid/address/wdata/wstrb/dma_len per burst. Moves data between memory and a
//  pair of valid/ready word streams: write stream in -> memory, memory -> read stream out.
// PARAMETERS
//  DATA_W     32   native/stream word width; BYTES = DATA_W/8
//  ADDR_W     32   native address width (equals AXI_ADDR_W)
//  LEN_W      8    dma_len width (equals AXI_LEN_W); max burst 2**LEN_W beats
//  CNT_W      16   transfer word-count width
//  MAX_BURST  16   burst beat cap, 1..2**LEN_W
// PORTS
//  clk        in   1        system clock
//  rst        in   1        synchronous active-high reset
//  start      in   1        1-cycle pulse: latch cfg, begin transfer (ignored while busy)
//  dir        in   1        0 = memory->m_t stream (read), 1 = s_t stream->memory (write)
//  base_addr  in   ADDR_W   start byte address; low log2(BYTES) bits forced to 0
//  nwords     in   CNT_W    words to transfer
//  busy       out  1        transfer in progress
//  done       out  1        1-cycle pulse at transfer end
//  err        out  1        sticky downstream error, cleared by next accepted start
//  s_tvalid   in   1        write-stream word valid
//  s_tdata    in   DATA_W   write-stream word
//  s_tready   out  1        write-stream accept
//  m_tvalid   out  1        read-stream word valid
//  m_tdata    out  DATA_W   read-stream word
//  m_tready   in   1        read-stream consumer ready
//  valid      out  1        native request to DMA
//  address    out  ADDR_W   native byte address of current beat
//  wdata      out  DATA_W   native write data
//  wstrb      out  BYTES    all-ones for write, 0 for read
//  rdata      in   DATA_W   native read data
//  ready      in   1        native beat accepted
//  dma_len    out  LEN_W    current burst beats-1
//  dma_ready  in   1        DMA idle, may accept a new burst
//  error      in   1        DMA error indication
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; m_t buffer empty; counters 0.
//  FSM: IDLE -> CALC on start (nwords!=0); IDLE -> DONE on start with nwords==0 (no bus
//   activity, done one cycle after start). CALC (1 cycle) -> WAIT -> XFER -> CALC if words
//   remain and no err, else DONE. DONE (1 cycle, done=1) -> IDLE.
//  CALC: beats = min(remaining, MAX_BURST, (4096 - addr[11:0])/BYTES); dma_len = beats-1,
//   held stable until burst ends. WAIT: waits dma_ready=1, no valid asserted.
//  XFER write: valid = s_tvalid; wdata = s_tdata; wstrb = all-ones; s_tready = ready & XFER.
//  XFER read: wstrb = 0; valid only when m_t buffer empty or draining this cycle
//   (m_tready & m_tvalid); rdata captured into m_tdata on ready, m_tvalid set.
//  Each ready beat: address += BYTES, remaining -= 1, beat count +1; burst ends after
//   beats handshakes. address = beat address, combinational-free (registered).
//  busy=1 from cycle after accepted start through DONE; m_t buffer may still hold last word
//   after done; next start accepted only when buffer empty.
//  error seen high in XFER/WAIT -> err set; current burst completes, then DONE (abort).
//  ready asserted outside XFER is ignored. rst mid-transfer returns to reset state at once;
//   pending stream word is discarded.
//  Address wraps modulo 2**ADDR_W; no carry out.
// CONFIGURATION
//  DMA_BURST_4K_EN defined: 4 KB boundary term included in CALC min(); no burst crosses a
//   4096-byte page. Undefined: beats = min(remaining, MAX_BURST) only; bursts may cross.
// TESTING
//  1 write, base 0x100, nwords 40, MAX_BURST 16, s_tvalid=1 -> dma_len 15,15,7; addresses
//    0x100..0x19C step 4; done after 40th ready; err=0.
//  2 read, base 0xFF8, nwords 4, 4K_EN -> bursts dma_len 1 (0xFF8,0xFFC) then 1 (0x1000,
//    0x1004); without macro single burst dma_len 3.
//  3 read, nwords 5, m_tready low for 20 cycles -> exactly one word buffered, valid held 0,
//    no data loss; all 5 words delivered in order once m_tready=1.
//  4 start with nwords 0 -> done pulse next cycle, valid never high, busy 0 afterwards.
//  5 write nwords 32, error pulsed during burst 1 -> burst 1 completes, no burst 2, done
//    pulse, err=1 until next start.
//  6 rst asserted mid-burst -> next cycle valid=0, busy=0, m_tvalid=0; new start works.

Source files
------------

// File: rtl/dma_burst_ctrl.sv
// dma_burst_ctrl: splits a programmed transfer into AXI-native bursts and moves words
// between memory and a pair of valid/ready word streams.
// Optional build macro: DMA_BURST_4K_EN (bursts never cross a 4096-byte page).
module dma_burst_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dir,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    nwords,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                s_tvalid,
  input  logic [DATA_W-1:0]   s_tdata,
  output logic                s_tready,
  output logic                m_tvalid,
  output logic [DATA_W-1:0]   m_tdata,
  input  logic                m_tready,
  output logic                valid,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ready,
  output logic [LEN_W-1:0]    dma_len,
  input  logic                dma_ready,
  input  logic                error
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned BW    = LEN_W + 1;                  // beats per burst, up to 2**LEN_W
  localparam int unsigned MW    = (CNT_W > 13) ? CNT_W : 13;  // width for the min() terms

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_WAIT = 3'd2,
    S_XFER = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_dir;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_rem;
  logic [LEN_W-1:0]    r_dma_len;
  logic [BW-1:0]       r_beats;
  logic [BW-1:0]       r_bcnt;
  logic                r_err;
  logic                r_m_tvalid;
  logic [DATA_W-1:0]   r_m_tdata;

  logic                w_start_ok;
  logic                w_valid;
  logic                w_beat;
  logic                w_last_beat;
  logic                w_err_set;
  logic [MW-1:0]       w_min;
  logic [BW-1:0]       w_beats_calc;

  // Start is taken only when idle and the read-stream buffer has drained
  assign w_start_ok  = start & (r_state == S_IDLE) & ~r_m_tvalid;
  assign w_beat      = w_valid & ready;
  assign w_last_beat = w_beat & (r_bcnt == (r_beats - BW'(1)));
  assign w_err_set   = error & ((r_state == S_WAIT) | (r_state == S_XFER));

  // Burst length: min of remaining words, beat cap and (optionally) words left in the page
  always_comb begin
    w_min = MW'(r_rem);
    if (MW'(MAX_BURST) < w_min) w_min = MW'(MAX_BURST);
`ifdef DMA_BURST_4K_EN
    if (MW'((13'd4096 - {1'b0, r_addr[11:0]}) / 13'(BYTES)) < w_min)
      w_min = MW'((13'd4096 - {1'b0, r_addr[11:0]}) / 13'(BYTES));
`else
`endif
    w_beats_calc = BW'(w_min);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and native/stream handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    s_tready    = 1'b0;
    wdata       = '0;
    wstrb       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = (nwords == '0) ? S_DONE : S_CALC;
      end
      S_CALC: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (dma_ready) w_state_nxt = S_XFER;
      end
      S_XFER: begin
        if (r_dir) begin
          w_valid  = s_tvalid;
          s_tready = ready;
          wdata    = s_tdata;
          wstrb    = '1;
        end else begin
          // Only request a word when the single-entry output buffer can take it
          w_valid  = ~r_m_tvalid | m_tready;
        end
        if (w_last_beat) begin
          if ((r_rem != CNT_W'(1)) && !r_err && !w_err_set) w_state_nxt = S_CALC;
          else                                              w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transfer datapath: config latch, burst sizing, beat counting, read buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir      <= 1'b0;
      r_addr     <= '0;
      r_rem      <= '0;
      r_dma_len  <= '0;
      r_beats    <= '0;
      r_bcnt     <= '0;
      r_err      <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
    end else begin
      if (w_start_ok) begin
        r_dir  <= dir;
        r_addr <= base_addr & ~ADDR_W'(BYTES - 1);
        r_rem  <= nwords;
        r_err  <= 1'b0;
      end else if (w_err_set) begin
        r_err  <= 1'b1;
      end
      if (r_state == S_CALC) begin
        r_dma_len <= LEN_W'(w_beats_calc - BW'(1));
        r_beats   <= w_beats_calc;
        r_bcnt    <= '0;
      end
      if (w_beat) begin
        r_addr <= r_addr + ADDR_W'(BYTES);
        r_rem  <= r_rem - CNT_W'(1);
        r_bcnt <= r_bcnt + BW'(1);
      end
      if (w_beat && !r_dir) begin
        r_m_tdata  <= rdata;
        r_m_tvalid <= 1'b1;
      end else if (m_tready && r_m_tvalid) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  // Status and registered outputs
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign err      = r_err;
  assign valid    = w_valid;
  assign address  = r_addr;
  assign dma_len  = r_dma_len;
  assign m_tvalid = r_m_tvalid;
  assign m_tdata  = r_m_tdata;

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Bench for dma_burst_ctrl: table of transfers plus hand sequences for abort, backpressure,
// zero-length and reset; per-beat and per-stream-word scoreboards.
module tb_dma_burst_ctrl;

  localparam int unsigned MAX_BURST = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] nwords = '0;
  logic        busy, done, err;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tready = 1'b0;
  logic        valid;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [7:0]  dma_len;
  logic        dma_ready = 1'b0;
  logic        error = 1'b0;
  logic        ack_en = 1'b0;

  dma_burst_ctrl #(.DATA_W(32), .ADDR_W(32), .LEN_W(8), .CNT_W(16), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .base_addr(base_addr), .nwords(nwords),
    .busy(busy), .done(done), .err(err),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tready(m_tready),
    .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb), .rdata(rdata),
    .ready(ready), .dma_len(dma_len), .dma_ready(dma_ready), .error(error)
  );

  // Native memory model: accepts when enabled, read data is the inverted address
  assign ready = valid & ack_en;
  assign rdata = ~address;

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        dir;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  len;
  } beat_t;

  typedef struct {
    logic        dir;
    logic [31:0] base;
    logic [15:0] n;
    bit          rnd;
    int          nb;
    logic [7:0]  last_len;
  } vec_t;

  beat_t       q_beat[$];
  logic [31:0] q_m[$];

  int   n_cmp = 0;
  int   n_fail = 0;
  bit   rnd = 1'b0;
  bit   hold_m = 1'b0;
  bit   s_acc = 1'b0;
  bit   m_acc = 1'b0;
  int   s_idx = 0;
  int   beats_seen = 0;
  int   bursts_seen = 0;
  int   valid_seen = 0;
  int   tb_bcnt = 0;
  logic [7:0] last_len = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Stimulus sources, updated just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    if (s_acc) s_idx++;
    s_tdata = 32'hC0DE_0000 + 32'(s_idx);
    if (rnd) begin
      s_tvalid  = ($urandom_range(3) != 0);
      ack_en    = ($urandom_range(3) != 0);
      dma_ready = ($urandom_range(4) != 0);
      m_tready  = !hold_m && ($urandom_range(2) != 0);
    end else begin
      s_tvalid  = 1'b1;
      ack_en    = 1'b1;
      dma_ready = 1'b1;
      m_tready  = !hold_m;
    end
  end

  // Monitor: score every native beat and every read-stream word on the falling edge
  initial forever begin
    beat_t e;
    logic [31:0] md;
    @(negedge clk);
    s_acc = s_tvalid & s_tready;
    m_acc = m_tvalid & m_tready;
    if (valid) valid_seen++;
    if (valid && ready) begin
      beats_seen++;
      if (tb_bcnt == 0) bursts_seen++;
      last_len = dma_len;
      tb_bcnt++;
      if (tb_bcnt == int'(dma_len) + 1) tb_bcnt = 0;
      if (q_beat.size() == 0) begin
        fail_now("extra_beat");
      end else begin
        e = q_beat.pop_front();
        chk("address", 64'(address), 64'(e.addr));
        chk("dma_len", 64'(dma_len), 64'(e.len));
        chk("wstrb", 64'(wstrb), e.dir ? 64'hF : 64'h0);
        if (e.dir) chk("wdata", 64'(wdata), 64'(e.wdata));
      end
    end
    if (m_acc) begin
      if (q_m.size() == 0) begin
        fail_now("extra_m_word");
      end else begin
        md = q_m.pop_front();
        chk("m_tdata", 64'(m_tdata), 64'(md));
      end
    end
  end

  // Reference burst split; abort keeps only the first burst
  task automatic push_model(input logic d, input logic [31:0] b, input int n, input bit abort);
    logic [31:0] a;
    int rem;
    int w;
    int beats;
    beat_t e;
    a   = b & ~32'h3;
    rem = n;
    w   = s_idx;
    while (rem > 0) begin
      beats = (rem < int'(MAX_BURST)) ? rem : int'(MAX_BURST);
`ifdef DMA_BURST_4K_EN
      if ((4096 - int'(a[11:0])) / 4 < beats) beats = (4096 - int'(a[11:0])) / 4;
`endif
      for (int i = 0; i < beats; i++) begin
        e.dir   = d;
        e.addr  = a;
        e.wdata = 32'hC0DE_0000 + 32'(w);
        e.len   = 8'(beats - 1);
        q_beat.push_back(e);
        if (d) w++;
        else   q_m.push_back(~a);
        a = a + 32'd4;
        rem--;
      end
      if (abort) break;
    end
  endtask

  task automatic start_xfer(input logic d, input logic [31:0] b, input logic [15:0] n,
                            input bit abort);
    @(negedge clk);
    push_model(d, b, int'(n), abort);
    tb_bcnt     = 0;
    beats_seen  = 0;
    bursts_seen = 0;
    valid_seen  = 0;
    dir         = d;
    base_addr   = b;
    nwords      = n;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic exp_err);
    int t;
    t = 0;
    while (!done && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      fail_now({name, "_done_timeout"});
    end else begin
      chk({name, "_err"}, 64'(err), 64'(exp_err));
      chk({name, "_beats_left"}, 64'(q_beat.size()), 64'd0);
      @(negedge clk);
      chk({name, "_busy_after"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((q_m.size() != 0 || m_tvalid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_words_left"}, 64'(q_m.size()), 64'd0);
  endtask

  initial begin
    vec_t tbl[7];
    int t;
    tbl[0] = '{1'b1, 32'h0000_0100, 16'd40, 1'b0, 3, 8'd7};
`ifdef DMA_BURST_4K_EN
    tbl[1] = '{1'b0, 32'h0000_0FF8, 16'd4,  1'b0, 2, 8'd1};
    tbl[4] = '{1'b1, 32'hFFFF_FFF8, 16'd4,  1'b1, 2, 8'd1};
    tbl[5] = '{1'b0, 32'h0000_0FD0, 16'd40, 1'b1, 3, 8'd11};
`else
    tbl[1] = '{1'b0, 32'h0000_0FF8, 16'd4,  1'b0, 1, 8'd3};
    tbl[4] = '{1'b1, 32'hFFFF_FFF8, 16'd4,  1'b1, 1, 8'd3};
    tbl[5] = '{1'b0, 32'h0000_0FD0, 16'd40, 1'b1, 3, 8'd7};
`endif
    tbl[2] = '{1'b1, 32'h0000_0000, 16'd1,  1'b1, 1, 8'd0};
    tbl[3] = '{1'b0, 32'h0000_2000, 16'd17, 1'b1, 2, 8'd0};
    tbl[6] = '{1'b1, 32'h0000_0003, 16'd3,  1'b0, 1, 8'd2};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_address", 64'(address), 64'd0);
    chk("rst_dma_len", 64'(dma_len), 64'd0);
    chk("rst_wstrb", 64'(wstrb), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-length transfer: done the cycle after start, no native activity
    start_xfer(1'b1, 32'h40, 16'd0, 1'b0);
    chk("zero_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("zero_done_clr", 64'(done), 64'd0);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_valid_seen", 64'(valid_seen), 64'd0);

    // Read with consumer stalled: one word buffered, no further requests
    hold_m = 1'b1;
    start_xfer(1'b0, 32'h300, 16'd5, 1'b0);
    repeat (20) @(negedge clk);
    chk("stall_m_tvalid", 64'(m_tvalid), 64'd1);
    chk("stall_beats", 64'(beats_seen), 64'd1);
    chk("stall_valid", 64'(valid), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    hold_m = 1'b0;
    wait_done("stall", 1'b0);
    wait_drain("stall");
    chk("stall_total_beats", 64'(beats_seen), 64'd5);

    // Error during first burst: burst finishes, then abort with sticky err
    start_xfer(1'b1, 32'h400, 16'd32, 1'b1);
    t = 0;
    while (beats_seen < 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (beats_seen < 3) fail_now("abort_no_beats");
    error = 1'b1;
    @(negedge clk);
    error = 1'b0;
    wait_done("abort", 1'b1);
    chk("abort_beats", 64'(beats_seen), 64'd16);
    chk("abort_bursts", 64'(bursts_seen), 64'd1);
    repeat (3) @(negedge clk);
    chk("abort_err_sticky", 64'(err), 64'd1);

    // Reset mid-burst with a word held in the read buffer
    hold_m = 1'b1;
    start_xfer(1'b0, 32'h900, 16'd8, 1'b0);
    repeat (6) @(negedge clk);
    chk("midrst_pre_m_tvalid", 64'(m_tvalid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    rst = 1'b0;
    q_beat.delete();
    q_m.delete();
    hold_m = 1'b0;
    repeat (2) @(negedge clk);

    // Table of transfers
    for (int i = 0; i < 7; i++) begin
      rnd = tbl[i].rnd;
      start_xfer(tbl[i].dir, tbl[i].base, tbl[i].n, 1'b0);
      wait_done($sformatf("vec%0d", i), 1'b0);
      wait_drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_beats", i), 64'(beats_seen), 64'(tbl[i].n));
      chk($sformatf("vec%0d_bursts", i), 64'(bursts_seen), 64'(tbl[i].nb));
      chk($sformatf("vec%0d_last_len", i), 64'(last_len), 64'(tbl[i].last_len));
      rnd = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
